aes_key_sched: RTL and testbench

AES_KEY_SCHED -- requirements
Module: aes_key_sched

---
 rtl/aes_key_sched_pkg.sv | 43 ++++
 rtl/aes_key_sched_if.sv | 35 +++
 rtl/aes_key_sched.sv | 197 +++++++++++++++++++
 tb/tb_aes_key_sched.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_sched_pkg.sv
// Shared AES definitions for the key schedule controller.
// Contents:
//   aes_op_e         - cipher direction (AES_ENC / AES_DEC)
//   aes_key_len_e    - one-hot key length (AES_128 / AES_192 / AES_256)
//   key_words_sel_e  - which 128-bit window of the 256-bit key register forms rk_o
//   num_rounds()     - round count for a key length
//   mod3()           - small modulo-3 helper for the AES-192 window rotation
package aes_key_sched_pkg;

  typedef enum logic {
    AES_ENC = 1'b0,
    AES_DEC = 1'b1
  } aes_op_e;

  typedef enum logic [2:0] {
    AES_128 = 3'b001,
    AES_192 = 3'b010,
    AES_256 = 3'b100
  } aes_key_len_e;

  typedef enum logic [1:0] {
    KEY_WORDS_0123 = 2'd0,
    KEY_WORDS_2345 = 2'd1,
    KEY_WORDS_4567 = 2'd2,
    KEY_WORDS_ZERO = 2'd3
  } key_words_sel_e;

  function automatic logic [3:0] num_rounds(input logic [2:0] key_len);
    logic [3:0] nr;
    case (key_len)
      AES_128: nr = 4'd10;
      AES_192: nr = 4'd12;
      AES_256: nr = 4'd14;
      default: nr = 4'd10;
    endcase
    return nr;
  endfunction

  function automatic logic [1:0] mod3(input logic [3:0] e);
    return 2'(e % 4'd3);
  endfunction

endpackage

// File: rtl/aes_key_sched_if.sv
// Control and round-key bus of the AES key schedule controller.
// Signal names are given from the controller's point of view.
//   start_i/ready_o   : a start is accepted in a cycle where start_i & ready_o.
//   mode_i, key_len_i, key_i : sampled together with an accepted start.
//   clear_i           : wipe request, accepted in any cycle.
//   err_o             : one-cycle pulse after a rejected start.
//   busy_o            : controller is not idle.
//   rk_o/rk_valid_o/rk_ready_i/rk_last_o : round-key stream.
// Handshake rule: a round key transfers in a cycle where rk_valid_o & rk_ready_i;
// while rk_valid_o=1 and rk_ready_i=0, rk_o and rk_last_o hold; rk_ready_i is
// ignored while rk_valid_o=0.
interface aes_key_sched_if;
  logic         start_i;
  logic         ready_o;
  logic         mode_i;
  logic [2:0]   key_len_i;
  logic [255:0] key_i;
  logic         clear_i;
  logic         err_o;
  logic         busy_o;
  logic [127:0] rk_o;
  logic         rk_valid_o;
  logic         rk_ready_i;
  logic         rk_last_o;

  modport slave (
    input  start_i, mode_i, key_len_i, key_i, clear_i, rk_ready_i,
    output ready_o, err_o, busy_o, rk_o, rk_valid_o, rk_last_o
  );

  modport master (
    output start_i, mode_i, key_len_i, key_i, clear_i, rk_ready_i,
    input  ready_o, err_o, busy_o, rk_o, rk_valid_o, rk_last_o
  );
endinterface

// File: rtl/aes_key_sched.sv
// AES key schedule controller. Sequences an external key expander (ke_* ports)
// to produce num_rounds+1 round keys for AES-128/192/256, in forward order for
// encryption and reverse order for decryption (after a forward pre-expansion).
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   bus           : control / round-key bus (aes_key_sched_if.slave)
//   ke_mode_o, ke_step_o, ke_clear_o, ke_round_o, ke_key_len_o, ke_key_o : to expander
//   ke_key_i      : next key from expander (combinational from ke_key_o)
//   dbg_state_o   : current FSM state encoding
module aes_key_sched
  import aes_key_sched_pkg::*;
#(
  parameter bit AES192Enable = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  aes_key_sched_if.slave bus,
  output logic           ke_mode_o,
  output logic           ke_step_o,
  output logic           ke_clear_o,
  output logic [3:0]     ke_round_o,
  output logic [2:0]     ke_key_len_o,
  output logic [255:0]   ke_key_o,
  input  logic [255:0]   ke_key_i,
  output logic [1:0]     dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DEC_EXPAND = 2'd1,
    ROUND      = 2'd2,
    CLEAR      = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [255:0]   key_full_q, key_full_d;
  logic [3:0]     round_q, round_d;
  logic           mode_q, mode_d;
  logic [2:0]     key_len_q, key_len_d;
  logic           init_q, init_d;
  logic           err_q, err_d;

  logic [3:0]     nr;
  logic [3:0]     e;
  logic           key_len_ok;
  logic           rk_valid, rk_last;
  key_words_sel_e sel;
  logic [127:0]   rk_sel;

  assign nr = num_rounds(key_len_q);

  assign key_len_ok = (bus.key_len_i == AES_128) || (bus.key_len_i == AES_256) ||
                      (AES192Enable && (bus.key_len_i == AES_192));

  always_comb begin
    state_d    = state_q;
    key_full_d = key_full_q;
    round_d    = round_q;
    mode_d     = mode_q;
    key_len_d  = key_len_q;
    init_d     = init_q;
    err_d      = 1'b0;
    ke_step_o  = 1'b0;
    ke_clear_o = 1'b0;
    ke_mode_o  = mode_q;
    rk_valid   = 1'b0;
    rk_last    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (key_len_ok) begin
            key_full_d = bus.key_i;
            mode_d     = bus.mode_i;
            key_len_d  = bus.key_len_i;
            round_d    = 4'd0;
            init_d     = 1'b1;
            state_d    = (bus.mode_i == AES_DEC) ? DEC_EXPAND : ROUND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DEC_EXPAND: begin
        // Walk the schedule forward to the last round key, then re-arm the
        // expander in the inverse direction.
        ke_mode_o = AES_ENC;
        if (init_q) begin
          ke_clear_o = 1'b1;
          init_d     = 1'b0;
        end else if (round_q < nr) begin
          ke_step_o  = 1'b1;
          key_full_d = ke_key_i;
          round_d    = round_q + 4'd1;
        end else begin
          ke_clear_o = 1'b1;
          ke_mode_o  = AES_DEC;
          round_d    = 4'd0;
          state_d    = ROUND;
        end
      end
      ROUND: begin
        if (init_q) begin
          ke_clear_o = 1'b1;
          init_d     = 1'b0;
        end else begin
          rk_valid = 1'b1;
          rk_last  = (round_q == nr);
          if (bus.rk_ready_i) begin
            if (rk_last) begin
              state_d = IDLE;
            end else begin
              ke_step_o  = 1'b1;
              key_full_d = ke_key_i;
              round_d    = round_q + 4'd1;
            end
          end
        end
      end
      CLEAR: begin
        ke_clear_o = 1'b1;
        key_full_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A wipe overrides any start, step or handshake in the same cycle.
    if (bus.clear_i) begin
      state_d    = CLEAR;
      key_full_d = '0;
      round_d    = 4'd0;
      init_d     = 1'b0;
      err_d      = 1'b0;
      ke_step_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      key_full_q <= '0;
      round_q    <= '0;
      mode_q     <= 1'b0;
      key_len_q  <= '0;
      init_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_full_q <= key_full_d;
      round_q    <= round_d;
      mode_q     <= mode_d;
      key_len_q  <= key_len_d;
      init_q     <= init_d;
      err_q      <= err_d;
    end
  end

  // Decryption consumes the schedule backwards, so the window index counts down.
  assign e = (mode_q == AES_DEC) ? (nr - round_q) : round_q;

  always_comb begin
    sel = KEY_WORDS_ZERO;
    case (key_len_q)
      AES_128: sel = KEY_WORDS_0123;
      AES_192: begin
        // Six-word register: round keys rotate through three overlapping windows.
        case (mod3(e))
          2'd0:    sel = KEY_WORDS_0123;
          2'd1:    sel = KEY_WORDS_4567;
          default: sel = KEY_WORDS_2345;
        endcase
      end
      AES_256: sel = (e == 4'd0) ? KEY_WORDS_0123 : KEY_WORDS_4567;
      default: sel = KEY_WORDS_ZERO;
    endcase

    case (sel)
      KEY_WORDS_0123: rk_sel = key_full_q[255:128];
      KEY_WORDS_2345: rk_sel = key_full_q[191:64];
      KEY_WORDS_4567: rk_sel = key_full_q[127:0];
      default:        rk_sel = '0;
    endcase
  end

  assign bus.rk_o       = rk_sel;
  assign bus.rk_valid_o = rk_valid;
  assign bus.rk_last_o  = rk_last;
  assign bus.ready_o    = (state_q == IDLE);
  assign bus.busy_o     = (state_q != IDLE);
  assign bus.err_o      = err_q;
  assign ke_round_o     = round_q;
  assign ke_key_len_o   = key_len_q;
  assign ke_key_o       = key_full_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// Testbench for aes_key_sched. Includes a behavioural AES key expander
// (AES-128 forward/inverse, AES-256 forward) and a simple word-increment
// expander for AES-192 window checks.
module tb_aes_key_sched;
  import aes_key_sched_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_key_sched_if bus();

  logic         ke_mode, ke_step, ke_clear;
  logic [3:0]   ke_round;
  logic [2:0]   ke_key_len;
  logic [255:0] ke_key_o_s, ke_key_i_s;
  logic [1:0]   dbg_state;

  aes_key_sched #(.AES192Enable(1'b1)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .ke_mode_o    (ke_mode),
    .ke_step_o    (ke_step),
    .ke_clear_o   (ke_clear),
    .ke_round_o   (ke_round),
    .ke_key_len_o (ke_key_len),
    .ke_key_o     (ke_key_o_s),
    .ke_key_i     (ke_key_i_s),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- key expander model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input int idx);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 0; k < idx; k++) r = r[7] ? ((r << 1) ^ 8'h1b) : (r << 1);
    return r;
  endfunction

  function automatic logic [255:0] model_expand(input logic [255:0] key, input logic [3:0] rnd,
                                                input logic mode, input logic [2:0] len);
    logic [31:0]  w [8];
    logic [31:0]  t, n0, n1, n2, n3;
    logic [255:0] res;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    res = key;
    case (len)
      3'b001: begin
        if (mode == 1'b0) begin
          t  = sub_word(rot_word(w[3])) ^ {rcon(int'(rnd)), 24'h0};
          n0 = w[0] ^ t; n1 = w[1] ^ n0; n2 = w[2] ^ n1; n3 = w[3] ^ n2;
        end else begin
          n3 = w[3] ^ w[2]; n2 = w[2] ^ w[1]; n1 = w[1] ^ w[0];
          n0 = w[0] ^ sub_word(rot_word(n3)) ^ {rcon(9 - int'(rnd)), 24'h0};
        end
        res = {n0, n1, n2, n3, key[127:0]};
      end
      3'b100: begin
        if (mode == 1'b0 && rnd != 4'd0) begin
          if (rnd[0]) t = sub_word(rot_word(w[7])) ^ {rcon((int'(rnd) - 1) / 2), 24'h0};
          else        t = sub_word(w[7]);
          n0 = w[0] ^ t; n1 = w[1] ^ n0; n2 = w[2] ^ n1; n3 = w[3] ^ n2;
          res = {w[4], w[5], w[6], w[7], n0, n1, n2, n3};
        end
      end
      3'b010: begin
        for (int i = 0; i < 8; i++) res[255-32*i -: 32] = w[i] + 32'd1;
      end
      default: res = key;
    endcase
    return res;
  endfunction

  always_comb ke_key_i_s = model_expand(ke_key_o_s, ke_round, ke_mode, ke_key_len);

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  localparam logic [255:0] KEY_128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic [127:0] cap [16];
  logic         cap_last [16];
  int           n_keys, n_steps, n_exp_enc_steps, first_valid_iter, stab_err, excl_err;
  logic         first_clear, first_mode, dec_clear_seen, timed_out;

  // ---------------- driver tasks ----------------
  task automatic run_schedule(input logic mode, input logic [2:0] len,
                              input logic [255:0] key, input bit rand_ready);
    logic [127:0] prev_rk;
    logic         prev_hold;
    bit           done;
    n_keys = 0; n_steps = 0; n_exp_enc_steps = 0; first_valid_iter = -1;
    stab_err = 0; excl_err = 0; dec_clear_seen = 1'b0;
    first_clear = 1'b0; first_mode = 1'b1;
    for (int i = 0; i < 16; i++) begin cap[i] = '0; cap_last[i] = 1'b0; end
    @(negedge clk);
    bus.start_i = 1'b1; bus.mode_i = mode; bus.key_len_i = len; bus.key_i = key;
    bus.rk_ready_i = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b0;
    prev_hold = 1'b0; prev_rk = '0; done = 1'b0;
    for (int it = 0; it < 200 && !done; it++) begin
      bus.rk_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (it == 0) begin first_clear = ke_clear; first_mode = ke_mode; end
      if (ke_step) begin
        n_steps++;
        if (!bus.rk_valid_o && ke_mode == 1'b0) n_exp_enc_steps++;
      end
      if (ke_step && ke_clear) excl_err++;
      if (it > 0 && ke_clear && ke_mode && !bus.rk_valid_o) dec_clear_seen = 1'b1;
      if (bus.rk_valid_o && first_valid_iter < 0) first_valid_iter = it;
      if (prev_hold && bus.rk_o !== prev_rk) stab_err++;
      prev_hold = bus.rk_valid_o && !bus.rk_ready_i;
      prev_rk   = bus.rk_o;
      if (bus.rk_valid_o && bus.rk_ready_i) begin
        if (n_keys < 16) begin cap[n_keys] = bus.rk_o; cap_last[n_keys] = bus.rk_last_o; end
        n_keys++;
        if (bus.rk_last_o) done = 1'b1;
      end
      @(negedge clk);
    end
    bus.rk_ready_i = 1'b0;
    timed_out = !done;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready_o); end
    checks++; if ({bus.busy_o, bus.err_o, bus.rk_valid_o, ke_step, ke_clear} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 00000", {bus.busy_o, bus.err_o, bus.rk_valid_o, ke_step, ke_clear}); end
    checks++; if (ke_key_o_s !== 256'h0) begin errors++; $display("FAIL reset_key: got %h expected 0", ke_key_o_s); end
  endtask

  task automatic test_enc128();
    run_schedule(1'b0, 3'b001, KEY_128, 1'b0);
    checks++; if (timed_out || n_keys !== 11) begin errors++; $display("FAIL enc128_count: got %0d timeout %b expected 11", n_keys, timed_out); end
    checks++; if (first_clear !== 1'b1 || first_mode !== 1'b0) begin errors++; $display("FAIL enc128_init_clear: got clear %b mode %b expected 1 0", first_clear, first_mode); end
    checks++; if (first_valid_iter !== 1) begin errors++; $display("FAIL enc128_latency: got %0d expected 1", first_valid_iter); end
    checks++; if (cap[0] !== 128'h000102030405060708090a0b0c0d0e0f) begin errors++; $display("FAIL enc128_rk0: got %h expected 000102030405060708090a0b0c0d0e0f", cap[0]); end
    checks++; if (cap[1] !== 128'hd6aa74fdd2af72fadaa678f1d6ab76fe) begin errors++; $display("FAIL enc128_rk1: got %h expected d6aa74fdd2af72fadaa678f1d6ab76fe", cap[1]); end
    checks++; if (cap[10] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin errors++; $display("FAIL enc128_rk10: got %h expected 13111d7fe3944a17f307a78b4d2b30c5", cap[10]); end
    checks++; if (cap_last[10] !== 1'b1 || cap_last[9] !== 1'b0) begin errors++; $display("FAIL enc128_last: got %b%b expected 01", cap_last[9], cap_last[10]); end
    checks++; if (n_steps !== 10) begin errors++; $display("FAIL enc128_steps: got %0d expected 10", n_steps); end
    #1;
    checks++; if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin errors++; $display("FAIL enc128_idle: got ready %b busy %b expected 1 0", bus.ready_o, bus.busy_o); end
  endtask

  task automatic test_enc256_random_ready();
    run_schedule(1'b0, 3'b100, KEY_256, 1'b1);
    checks++; if (timed_out || n_keys !== 15) begin errors++; $display("FAIL enc256_count: got %0d timeout %b expected 15", n_keys, timed_out); end
    checks++; if (cap[1] !== 128'h101112131415161718191a1b1c1d1e1f) begin errors++; $display("FAIL enc256_rk1: got %h expected 101112131415161718191a1b1c1d1e1f", cap[1]); end
    checks++; if (cap[2] !== 128'ha573c29fa176c498a97fce93a572c09c) begin errors++; $display("FAIL enc256_rk2: got %h expected a573c29fa176c498a97fce93a572c09c", cap[2]); end
    checks++; if (cap[14] !== 128'h24fc79ccbf0979e9371ac23c6d68de36 || cap_last[14] !== 1'b1) begin
      errors++; $display("FAIL enc256_rk14: got %h last %b expected 24fc79ccbf0979e9371ac23c6d68de36 1", cap[14], cap_last[14]); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL enc256_hold: got %0d unstable cycles expected 0", stab_err); end
    checks++; if (n_steps !== 14) begin errors++; $display("FAIL enc256_steps: got %0d expected 14", n_steps); end
    checks++; if (excl_err !== 0) begin errors++; $display("FAIL enc256_excl: got %0d overlaps expected 0", excl_err); end
  endtask

  task automatic test_dec128();
    run_schedule(1'b1, 3'b001, KEY_128, 1'b0);
    checks++; if (timed_out || n_keys !== 11) begin errors++; $display("FAIL dec128_count: got %0d timeout %b expected 11", n_keys, timed_out); end
    checks++; if (n_exp_enc_steps !== 10) begin errors++; $display("FAIL dec128_expand_steps: got %0d expected 10", n_exp_enc_steps); end
    checks++; if (dec_clear_seen !== 1'b1) begin errors++; $display("FAIL dec128_dec_clear: got %b expected 1", dec_clear_seen); end
    checks++; if (first_valid_iter !== 12) begin errors++; $display("FAIL dec128_latency: got %0d expected 12", first_valid_iter); end
    checks++; if (cap[0] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin errors++; $display("FAIL dec128_rk_first: got %h expected 13111d7fe3944a17f307a78b4d2b30c5", cap[0]); end
    checks++; if (cap[1] !== 128'h549932d1f08557681093ed9cbe2c974e) begin errors++; $display("FAIL dec128_rk_second: got %h expected 549932d1f08557681093ed9cbe2c974e", cap[1]); end
    checks++; if (cap[10] !== 128'h000102030405060708090a0b0c0d0e0f || cap_last[10] !== 1'b1) begin
      errors++; $display("FAIL dec128_rk_last: got %h last %b expected 000102030405060708090a0b0c0d0e0f 1", cap[10], cap_last[10]); end
    checks++; if (n_steps !== 20) begin errors++; $display("FAIL dec128_total_steps: got %0d expected 20", n_steps); end
  endtask

  task automatic test_enc192_windows();
    run_schedule(1'b0, 3'b010, KEY_256, 1'b0);
    checks++; if (timed_out || n_keys !== 13 || cap_last[12] !== 1'b1) begin
      errors++; $display("FAIL enc192_count: got %0d last %b expected 13 1", n_keys, cap_last[12]); end
    checks++; if (cap[0] !== 128'h000102030405060708090a0b0c0d0e0f) begin errors++; $display("FAIL enc192_e0: got %h expected 000102030405060708090a0b0c0d0e0f", cap[0]); end
    checks++; if (cap[1] !== 128'h10111214141516181819_1a1c1c1d1e20) begin errors++; $display("FAIL enc192_e1: got %h expected 1011121414151618181 91a1c1c1d1e20", cap[1]); end
    checks++; if (cap[2] !== 128'h08090a0d0c0d0e111011121514151619) begin errors++; $display("FAIL enc192_e2: got %h expected 08090a0d0c0d0e111011121514151619", cap[2]); end
    checks++; if (cap[3] !== 128'h000102060405060a08090a0e0c0d0e12) begin errors++; $display("FAIL enc192_e3: got %h expected 000102060405060a08090a0e0c0d0e12", cap[3]); end
    checks++; if (n_steps !== 12) begin errors++; $display("FAIL enc192_steps: got %0d expected 12", n_steps); end
  endtask

  task automatic test_clear_mid();
    int hs;
    @(negedge clk);
    bus.start_i = 1'b1; bus.mode_i = 1'b0; bus.key_len_i = 3'b001; bus.key_i = KEY_128;
    @(negedge clk);
    bus.start_i = 1'b0;
    hs = 0;
    for (int it = 0; it < 50 && hs < 5; it++) begin
      bus.rk_ready_i = 1'b1;
      #1;
      if (bus.rk_valid_o) hs++;
      @(negedge clk);
    end
    bus.rk_ready_i = 1'b1; bus.clear_i = 1'b1;
    #1;
    checks++; if (hs !== 5 || bus.rk_valid_o !== 1'b1) begin errors++; $display("FAIL clear_reach_round5: got %0d valid %b expected 5 1", hs, bus.rk_valid_o); end
    checks++; if (ke_step !== 1'b0) begin errors++; $display("FAIL clear_no_step: got %b expected 0", ke_step); end
    @(negedge clk);
    bus.clear_i = 1'b0; bus.rk_ready_i = 1'b0;
    #1;
    checks++; if (ke_key_o_s !== 256'h0) begin errors++; $display("FAIL clear_key_zero: got %h expected 0", ke_key_o_s); end
    checks++; if (ke_clear !== 1'b1 || bus.rk_valid_o !== 1'b0 || bus.ready_o !== 1'b0) begin
      errors++; $display("FAIL clear_state: got clear %b valid %b ready %b expected 1 0 0", ke_clear, bus.rk_valid_o, bus.ready_o); end
    @(negedge clk);
    #1;
    checks++; if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0 || ke_clear !== 1'b0) begin
      errors++; $display("FAIL clear_to_idle: got ready %b busy %b clear %b expected 1 0 0", bus.ready_o, bus.busy_o, ke_clear); end
  endtask

  task automatic test_reject();
    logic [2:0] bad_len [2];
    bad_len[0] = 3'b011; bad_len[1] = 3'b000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.start_i = 1'b1; bus.key_len_i = bad_len[i]; bus.mode_i = 1'b0;
      @(negedge clk);
      bus.start_i = 1'b0;
      #1;
      checks++; if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.ready_o !== 1'b1) begin
        errors++; $display("FAIL reject_%b: got err %b busy %b ready %b expected 1 0 1", bad_len[i], bus.err_o, bus.busy_o, bus.ready_o); end
      @(negedge clk);
      #1;
      checks++; if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b0) begin
        errors++; $display("FAIL reject_pulse_%b: got err %b busy %b expected 0 0", bad_len[i], bus.err_o, bus.busy_o); end
    end
  endtask

  task automatic test_reset_mid_dec();
    int strobes;
    @(negedge clk);
    bus.start_i = 1'b1; bus.mode_i = 1'b1; bus.key_len_i = 3'b001; bus.key_i = KEY_128;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL rstdec_in_expand: got state %0d expected 1", dbg_state); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin errors++; $display("FAIL rstdec_ready: got ready %b busy %b expected 1 0", bus.ready_o, bus.busy_o); end
    checks++; if ({ke_step, ke_clear, ke_mode, bus.rk_valid_o, bus.err_o, ke_round} !== 9'b0 || ke_key_o_s !== 256'h0 || bus.rk_o !== 128'h0) begin
      errors++; $display("FAIL rstdec_outputs: got %b key %h rk %h expected all zero", {ke_step, ke_clear, ke_mode, bus.rk_valid_o, bus.err_o, ke_round}, ke_key_o_s, bus.rk_o); end
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (ke_step || ke_clear || bus.rk_valid_o) strobes++;
    end
    checks++; if (strobes !== 0) begin errors++; $display("FAIL rstdec_quiet: got %0d strobe cycles expected 0", strobes); end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0; bus.mode_i = 1'b0; bus.key_len_i = 3'b000; bus.key_i = '0;
    bus.clear_i = 1'b0; bus.rk_ready_i = 1'b0;
    test_reset();
    test_enc128();
    test_enc256_random_ready();
    test_dec128();
    test_enc192_windows();
    test_clear_mid();
    test_reject();
    test_reset_mid_dec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
